// File: rtl/fetch_sequencer.sv
// Control sequencer for the 8-bit fetch unit: launch, load, run with branch/stall/halt steering.
// Optional fetch-count watchdog halt is built only when FETCH_WATCHDOG_EN is defined.
module fetch_sequencer #(
  parameter int PC_W = 8,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic             f_clk,
  input  logic             reset,
  input  logic             go,
  input  logic [PC_W-1:0]  go_addr,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic [PC_W-1:0]  pc_i,
  output logic             fu_start,
  output logic [PC_W-1:0]  fu_start_addr,
  output logic             fu_branch,
  output logic             fu_taken,
  output logic [PC_W-1:0]  fu_target,
  output logic             busy,
  output logic             done,
  output logic [PC_W-1:0]  halt_pc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             wdog_trip
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             done_q, done_d;
  logic             wdog_hit;
  logic             halt_req;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef FETCH_WATCHDOG_EN
  logic wdog_trip_q, wdog_trip_d;

  assign wdog_hit = (state_q == RUN) && (fetch_cnt_q == WDOG_LIMIT);

  always_comb begin
    wdog_trip_d = wdog_trip_q;
    if (state_q == LOAD)
      wdog_trip_d = 1'b0;
    else if (wdog_hit)
      wdog_trip_d = 1'b1;
  end

  always_ff @(posedge f_clk or posedge reset) begin
    if (reset) wdog_trip_q <= 1'b0;
    else       wdog_trip_q <= wdog_trip_d;
  end

  assign wdog_trip = wdog_trip_q;
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_hit  = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  assign halt_req = halt_i || wdog_hit;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    halt_pc_d     = halt_pc_q;
    fetch_cnt_d   = fetch_cnt_q;
    done_d        = 1'b0;
    fu_start      = 1'b0;
    fu_start_addr = addr_q;
    fu_branch     = 1'b0;
    fu_taken      = 1'b0;
    fu_target     = pc_i;

    unique case (state_q)
      IDLE: begin
        fu_start = 1'b1;
        if (go) begin
          addr_d  = go_addr;
          state_d = LOAD;
        end
      end
      LOAD: begin
        fu_start    = 1'b1;
        fetch_cnt_d = '0;
        state_d     = RUN;
      end
      RUN: begin
        // Halt and stall both hold the PC by forcing a taken branch to itself.
        if (halt_req) begin
          fu_branch = 1'b1;
          fu_taken  = 1'b1;
          halt_pc_d = pc_i;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (stall_i) begin
          fu_branch = 1'b1;
          fu_taken  = 1'b1;
        end else begin
          fetch_cnt_d = sat_inc(fetch_cnt_q);
          if (br_valid) begin
            fu_branch = 1'b1;
            fu_taken  = br_taken;
            fu_target = br_target;
          end
        end
      end
      DONE: begin
        fu_branch = 1'b1;
        fu_taken  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge f_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      halt_pc_q   <= '0;
      fetch_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      halt_pc_q   <= halt_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == LOAD) || (state_q == RUN);
  assign done      = done_q;
  assign halt_pc   = halt_pc_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a simple fetch-unit PC register closes the loop,
// and a program-level model predicts PC and fetch count.
module tb_fetch_sequencer;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WDOG = 16'd4;

  logic             f_clk = 1'b0;
  logic             reset;
  logic             go;
  logic [PC_W-1:0]  go_addr;
  logic             halt_i, stall_i, br_valid, br_taken;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  pc_i;
  logic             fu_start, fu_branch, fu_taken, busy, done, wdog_trip;
  logic [PC_W-1:0]  fu_start_addr, fu_target, halt_pc;
  logic [CNT_W-1:0] fetch_cnt;

  fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG)) dut (
    .f_clk(f_clk), .reset(reset), .go(go), .go_addr(go_addr),
    .halt_i(halt_i), .stall_i(stall_i), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .pc_i(pc_i), .fu_start(fu_start), .fu_start_addr(fu_start_addr),
    .fu_branch(fu_branch), .fu_taken(fu_taken), .fu_target(fu_target), .busy(busy),
    .done(done), .halt_pc(halt_pc), .fetch_cnt(fetch_cnt), .wdog_trip(wdog_trip)
  );

  always #5 f_clk = ~f_clk;

  // Fetch unit: load on start, jump on taken branch, otherwise increment.
  logic [PC_W-1:0] fu_pc = 8'h00;
  assign pc_i = fu_pc;
  always @(posedge f_clk) begin
    if (fu_start)                   fu_pc <= fu_start_addr;
    else if (fu_branch && fu_taken) fu_pc <= fu_target;
    else                            fu_pc <= fu_pc + 8'd1;
  end

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] m_pc;
  int unsigned     m_cnt;
  logic [PC_W-1:0] last_addr;

  task automatic tick;
    @(posedge f_clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic s, input logic bv, input logic bt,
                       input logic [PC_W-1:0] tg);
    halt_i = h; stall_i = s; br_valid = bv; br_taken = bt; br_target = tg;
  endtask

  // Program-level reference: a non-stalled run cycle retires one fetch and moves the PC.
  function automatic void model_fetch(input logic s, input logic bv, input logic bt,
                                      input logic [PC_W-1:0] tg);
    if (!s) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      m_pc = (bv && bt) ? tg : m_pc + 8'd1;
    end
  endfunction

  task automatic test_reset;
    reset = 1'b1; go = 1'b0; go_addr = 8'h00;
    drive(0, 0, 0, 0, 8'h00);
    tick; tick;
    checks++; if (fu_start !== 1'b1) begin errors++; $display("FAIL rst_fu_start got %b want 1", fu_start); end
    checks++; if (fu_start_addr !== 8'h00) begin errors++; $display("FAIL rst_start_addr got %h want 00", fu_start_addr); end
    checks++; if (fu_branch !== 1'b0 || fu_taken !== 1'b0) begin errors++; $display("FAIL rst_branch got %b%b want 00", fu_branch, fu_taken); end
    checks++; if (fu_target !== pc_i) begin errors++; $display("FAIL rst_target got %h want %h", fu_target, pc_i); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    checks++; if (halt_pc !== 8'h00 || fetch_cnt !== 16'h0) begin errors++; $display("FAIL rst_regs got %h/%h want 00/0000", halt_pc, fetch_cnt); end
    checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL rst_wdog got %b want 0", wdog_trip); end
    reset = 1'b0;
    tick;
    checks++; if (fu_start !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold got start=%b busy=%b want 1/0", fu_start, busy); end
  endtask

  task automatic test_launch;
    go = 1'b1; go_addr = 8'h10;
    tick;
    go = 1'b0; go_addr = 8'hAA;
    checks++; if (busy !== 1'b1 || fu_start !== 1'b1) begin errors++; $display("FAIL load_state got busy=%b start=%b want 1/1", busy, fu_start); end
    checks++; if (fu_start_addr !== 8'h10) begin errors++; $display("FAIL load_addr got %h want 10", fu_start_addr); end
    tick;
    last_addr = 8'h10; m_pc = 8'h10; m_cnt = 0;
    checks++; if (pc_i !== 8'h10 || fu_start !== 1'b0) begin errors++; $display("FAIL run_first got pc=%h start=%b want 10/0", pc_i, fu_start); end
    checks++; if (fetch_cnt !== 16'd0) begin errors++; $display("FAIL run_cnt0 got %0d want 0", fetch_cnt); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 8'h00);
      model_fetch(0, 0, 0, 8'h00);
      tick;
      checks++; if (pc_i !== m_pc || busy !== 1'b1) begin errors++; $display("FAIL run_inc got pc=%h busy=%b want %h/1", pc_i, busy, m_pc); end
      checks++; if (fetch_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL run_inc_cnt got %0d want %0d", fetch_cnt, m_cnt); end
    end
    checks++; if (pc_i !== 8'h12) begin errors++; $display("FAIL run_pc12 got %h want 12", pc_i); end
  endtask

  task automatic test_branch;
    drive(0, 0, 1, 1, 8'h05); model_fetch(0, 1, 1, 8'h05); tick;
    checks++; if (pc_i !== 8'h05) begin errors++; $display("FAIL br_taken got %h want 05", pc_i); end
    checks++; if (fetch_cnt !== 16'd3) begin errors++; $display("FAIL br_taken_cnt got %0d want 3", fetch_cnt); end
    drive(0, 0, 1, 1, 8'h12); model_fetch(0, 1, 1, 8'h12); tick;
    drive(0, 0, 1, 0, 8'hE7); model_fetch(0, 1, 0, 8'hE7); tick;
    checks++; if (pc_i !== 8'h13) begin errors++; $display("FAIL br_not_taken got %h want 13", pc_i); end
    checks++; if (fetch_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL br_cnt got %0d want %0d", fetch_cnt, m_cnt); end
  endtask

  task automatic test_stall;
    logic [PC_W-1:0] tg;
    drive(0, 0, 1, 1, 8'h20); model_fetch(0, 1, 1, 8'h20); tick;
    checks++; if (pc_i !== 8'h20) begin errors++; $display("FAIL stall_setup got %h want 20", pc_i); end
    for (int i = 0; i < 3; i++) begin
      tg = 8'($urandom_range(0, 255));
      drive(0, 1, 1, 1, tg);
      #1;
      checks++; if (fu_branch !== 1'b1 || fu_taken !== 1'b1 || fu_target !== 8'h20) begin errors++; $display("FAIL stall_drive got %b%b %h want 11 20", fu_branch, fu_taken, fu_target); end
      model_fetch(1, 1, 1, tg);
      tick;
      checks++; if (pc_i !== 8'h20 || fetch_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL stall_hold got pc=%h cnt=%0d want 20/%0d", pc_i, fetch_cnt, m_cnt); end
    end
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_random;
    logic s, bv, bt;
    logic [PC_W-1:0] tg;
    for (int i = 0; i < 300; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      bv = $urandom_range(0, 1) == 1;
      bt = $urandom_range(0, 1) == 1;
      tg = 8'($urandom_range(0, 255));
      drive(0, s, bv, bt, tg);
      model_fetch(s, bv, bt, tg);
      tick;
      checks++; if (pc_i !== m_pc || fetch_cnt !== 16'(m_cnt) || busy !== 1'b1) begin errors++; $display("FAIL rand_%0d got pc=%h cnt=%0d busy=%b want %h/%0d/1", i, pc_i, fetch_cnt, busy, m_pc, m_cnt); end
    end
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_halt;
    drive(0, 0, 1, 1, 8'h33); model_fetch(0, 1, 1, 8'h33); tick;
    drive(1, 0, 1'($urandom_range(0, 1)), 1, 8'($urandom_range(0, 255)));
    #1;
    checks++; if (fu_branch !== 1'b1 || fu_taken !== 1'b1 || fu_target !== 8'h33) begin errors++; $display("FAIL halt_drive got %b%b %h want 11 33", fu_branch, fu_taken, fu_target); end
    tick;
    drive(0, 0, 0, 0, 8'h00);
    go = 1'b1; go_addr = 8'h77;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL halt_done got done=%b busy=%b want 1/0", done, busy); end
    checks++; if (halt_pc !== 8'h33 || pc_i !== 8'h33) begin errors++; $display("FAIL halt_pc got %h pc=%h want 33/33", halt_pc, pc_i); end
    checks++; if (fu_start !== 1'b0 || fu_branch !== 1'b1 || fu_taken !== 1'b1) begin errors++; $display("FAIL done_drive got %b%b%b want 011", fu_start, fu_branch, fu_taken); end
    tick;
    go = 1'b1; go_addr = 8'h40;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || fu_start !== 1'b1) begin errors++; $display("FAIL idle_after_done got done=%b busy=%b start=%b want 0/0/1", done, busy, fu_start); end
    checks++; if (fu_start_addr !== last_addr) begin errors++; $display("FAIL go_in_done got %h want %h", fu_start_addr, last_addr); end
    tick;
    go = 1'b0;
    checks++; if (busy !== 1'b1 || fu_start_addr !== 8'h40) begin errors++; $display("FAIL relaunch_load got busy=%b addr=%h want 1/40", busy, fu_start_addr); end
    tick;
    last_addr = 8'h40; m_pc = 8'h40; m_cnt = 0;
    checks++; if (pc_i !== 8'h40 || fetch_cnt !== 16'd0) begin errors++; $display("FAIL relaunch_run got pc=%h cnt=%0d want 40/0", pc_i, fetch_cnt); end
    checks++; if (halt_pc !== 8'h33) begin errors++; $display("FAIL halt_pc_keep got %h want 33", halt_pc); end
  endtask

  task automatic test_reset_midrun;
    drive(0, 0, 1, 1, 8'h57); model_fetch(0, 1, 1, 8'h57); tick;
    checks++; if (pc_i !== 8'h57 || fu_start !== 1'b0) begin errors++; $display("FAIL mid_setup got pc=%h start=%b want 57/0", pc_i, fu_start); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (fu_start !== 1'b1 || fu_start_addr !== 8'h00) begin errors++; $display("FAIL mid_rst_start got %b %h want 1 00", fu_start, fu_start_addr); end
    checks++; if (busy !== 1'b0 || fetch_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_state got busy=%b cnt=%0d want 0/0", busy, fetch_cnt); end
    checks++; if (fu_branch !== 1'b0 || fu_target !== pc_i) begin errors++; $display("FAIL mid_rst_steer got %b %h want 0 %h", fu_branch, fu_target, pc_i); end
    tick;
    reset = 1'b0;
    tick;
    checks++; if (fu_start !== 1'b1 || busy !== 1'b0 || pc_i !== 8'h00) begin errors++; $display("FAIL post_rst got start=%b busy=%b pc=%h want 1/0/00", fu_start, busy, pc_i); end
  endtask

  task automatic test_watchdog;
    drive(0, 0, 0, 0, 8'h00);
    go = 1'b1; go_addr = 8'h00;
    tick;
    go = 1'b0;
    tick;
    m_pc = 8'h00; m_cnt = 0;
`ifdef FETCH_WATCHDOG_EN
    for (int i = 0; i < 4; i++) begin
      model_fetch(0, 0, 0, 8'h00);
      tick;
    end
    checks++; if (pc_i !== 8'h04 || fetch_cnt !== 16'd4) begin errors++; $display("FAIL wd_reach got pc=%h cnt=%0d want 04/4", pc_i, fetch_cnt); end
    checks++; if (fu_branch !== 1'b1 || fu_taken !== 1'b1 || fu_target !== 8'h04) begin errors++; $display("FAIL wd_drive got %b%b %h want 11 04", fu_branch, fu_taken, fu_target); end
    tick;
    checks++; if (done !== 1'b1 || wdog_trip !== 1'b1 || halt_pc !== 8'h04) begin errors++; $display("FAIL wd_halt got done=%b trip=%b hpc=%h want 1/1/04", done, wdog_trip, halt_pc); end
    tick;
    checks++; if (wdog_trip !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd_sticky got trip=%b busy=%b want 1/0", wdog_trip, busy); end
`else
    for (int i = 0; i < 8; i++) begin
      model_fetch(0, 0, 0, 8'h00);
      tick;
      checks++; if (done !== 1'b0 || wdog_trip !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nowd_run got done=%b trip=%b busy=%b want 0/0/1", done, wdog_trip, busy); end
    end
    checks++; if (pc_i !== m_pc || fetch_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL nowd_pc got pc=%h cnt=%0d want %h/%0d", pc_i, fetch_cnt, m_pc, m_cnt); end
`endif
  endtask

  initial begin
    test_reset();
`ifdef FETCH_WATCHDOG_EN
    test_watchdog();
`else
    test_launch();
    test_branch();
    test_stall();
    test_random();
    test_halt();
    test_reset_midrun();
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer for the 8-bit fetch unit. Accepts a program-launch request, holds the fetch unit in start/load, then runs it while steering its branch/taken/target inputs from decode-stage branch resolution, stall and halt requests. Sits between the decode/control logic and `fetch_unit`, and reports busy/done status, halt PC and retired-fetch count.

## Interface
- `PC_W`, 8, PC width; must match the fetch unit.
- `CNT_W`, 16, width of the fetch counter.
- `WDOG_LIMIT`, 16'hFFFF, fetch count that forces a halt; used only when `FETCH_WATCHDOG_EN` is defined.

- `f_clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `go`  in  1  launch request; sampled only in IDLE.
- `go_addr`  in  PC_W  program start address, captured with `go`.
- `halt_i`  in  1  decoded halt instruction; RUN only.
- `stall_i`  in  1  hold the current PC this cycle; RUN only.
- `br_valid`  in  1  a branch is resolved this cycle.
- `br_taken`  in  1  resolved branch outcome; qualified by `br_valid`.
- `br_target`  in  PC_W  branch destination.
- `pc_i`  in  PC_W  current PC from the fetch unit.
- `fu_start`  out  1  to `fetch_unit.start`.
- `fu_start_addr`  out  PC_W  to `fetch_unit.start_addr`.
- `fu_branch`  out  1  to `fetch_unit.branch`.
- `fu_taken`  out  1  to `fetch_unit.taken`.
- `fu_target`  out  PC_W  to `fetch_unit.target`.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  registered one-cycle pulse on halt.
- `halt_pc`  out  PC_W  `pc_i` captured at halt.
- `fetch_cnt`  out  CNT_W  fetches advanced since last launch.
- `wdog_trip`  out  1  sticky watchdog-halt flag.

## Operation
- States: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11.
- IDLE:
  - `fu_start`=1 and `fu_start_addr`=`addr_q`, so the fetch unit is held at that address.
  - `go`=1 captures `go_addr` into `addr_q` and moves to LOAD.
- LOAD:
  - `fu_start`=1 with the new `addr_q`.
  - Clears `fetch_cnt` and `wdog_trip`.
  - Moves to RUN unconditionally.
- RUN: `fu_start`=0. Steering is combinational, in priority order:
  - Halt (`halt_i`, or watchdog): `fu_branch`=`fu_taken`=1, `fu_target`=`pc_i`. Captures `halt_pc`<=`pc_i`, moves to DONE.
  - Stall (`stall_i`): same PC-hold drive as halt; state is unchanged.
  - Branch (`br_valid`): `fu_branch`=1, `fu_taken`=`br_taken`, `fu_target`=`br_target`.
  - Otherwise: `fu_branch`=`fu_taken`=0 and `fu_target`=`pc_i`, so the PC increments.
- DONE:
  - `done`=1 for this one cycle.
  - PC-hold drive, `fu_start`=0.
  - Moves to IDLE.
- `fetch_cnt` increments in RUN on cycles with neither halt nor stall, taken branches included. It saturates at all-ones and never wraps.
- `go` outside IDLE is ignored; there is no queuing.
- `br_*` inputs outside RUN are ignored.
- `busy` = state is LOAD or RUN.

## Timing
- Reset values:
  - State IDLE, `addr_q`=0, `fetch_cnt`=0, `halt_pc`=0, `done`=0, `wdog_trip`=0.
  - Outputs during reset: `fu_start`=1, `fu_start_addr`=0, `fu_branch`=`fu_taken`=0, `fu_target`=`pc_i`, `busy`=0.
- Reset asserted mid-run returns to IDLE immediately (asynchronous). `fu_start` rises in the same cycle, without waiting for a clock edge.
- Launch latency, with `go` sampled at edge k:
  - LOAD occupies cycle k+1.
  - The fetch unit loads `go_addr` at edge k+2.
  - RUN starts in cycle k+2; the first increment of the PC is at edge k+3.
- Branch, stall and halt are zero-latency: combinational from the inputs to the `fu_*` outputs, taking effect at the next edge.
- Halt seen at edge h: `done` is high in cycle h+1, `busy` falls in cycle h+1, IDLE is reached in cycle h+2.
- `go` is accepted in the IDLE cycle immediately following DONE.

## Configuration
- `FETCH_WATCHDOG_EN` defined:
  - In RUN, `fetch_cnt`==`WDOG_LIMIT` is treated as a halt with the same priority as `halt_i`.
  - Sets `wdog_trip`=1, which stays set until the next LOAD.
  - If `halt_i` arrives in the same cycle, the halt is taken and `wdog_trip` is still set.
- Not defined: no watchdog logic is built, `wdog_trip` is tied to 0 and `WDOG_LIMIT` is unused.

## Test plan
- Reset, then `go`=1 with `go_addr`=8'h10 for one cycle -> LOAD for one cycle, then `pc_i` reads 10, 11, 12 on successive cycles with `busy`=1.
- In RUN at PC 8'h12: `br_valid`=1, `br_taken`=1, `br_target`=8'h05 -> next PC 05, `fetch_cnt` counts that cycle. With `br_taken`=0 -> next PC 13.
- Three cycles of `stall_i`=1 at PC 8'h20 with `br_valid`=1 held -> PC stays 20, `fetch_cnt` unchanged. Stall wins over the branch.
- `halt_i`=1 at PC 8'h33 -> `halt_pc`=33 and a single-cycle `done` pulse, then IDLE. A `go` asserted during DONE is ignored; `go` with 8'h40 in IDLE relaunches and `fetch_cnt` clears to 0.
- `reset` pulsed mid-RUN at PC 8'h57 -> `fu_start`=1 immediately, `fu_start_addr`=0, `busy`=0, `fetch_cnt`=0.
- With `FETCH_WATCHDOG_EN` and `WDOG_LIMIT`=16'd4: launch at 8'h00, no branches -> halt at `pc_i`=04, `wdog_trip`=1, `halt_pc`=04. Without the macro, the same stimulus runs past 8'h04 and `wdog_trip` stays 0.
